// File: rtl/gcd_ctrl_fsm.sv
// Control sequencer for the 8-bit GCD datapath: repeated-subtraction loop with a
// start/done host handshake and an error abort on zero operands or iteration overrun.
module gcd_ctrl_fsm #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic x_eq_y,
    input  logic x_gt_y,
    input  logic x_zero,
    input  logic y_zero,
    output logic x_sel,
    output logic y_sel,
    output logic x_ld,
    output logic y_ld,
    output logic out_ld,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_SUBX  = 3'd3,
        S_SUBY  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;
    logic              x_sel_q, x_sel_d;
    logic              y_sel_q, y_sel_d;
    logic              x_ld_q, x_ld_d;
    logic              y_ld_q, y_ld_d;
    logic              out_ld_q, out_ld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Saturating increment so an overrun can never wrap back below MAX_ITER.
    assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ITER_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (x_zero || y_zero) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (x_eq_y) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == MAX_CNT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (x_gt_y) begin
                    state_d = S_SUBX;
                end else begin
                    state_d = S_SUBY;
                end
            end
            S_SUBX: begin
                cnt_d   = cnt_inc;
                state_d = S_CHECK;
            end
            S_SUBY: begin
                cnt_d   = cnt_inc;
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        x_sel_d  = (state_d == S_LOAD);
        y_sel_d  = (state_d == S_LOAD);
        x_ld_d   = (state_d == S_LOAD) || (state_d == S_SUBX);
        y_ld_d   = (state_d == S_LOAD) || (state_d == S_SUBY);
        out_ld_d = (state_d == S_DONE);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            x_sel_q  <= 1'b0;
            y_sel_q  <= 1'b0;
            x_ld_q   <= 1'b0;
            y_ld_q   <= 1'b0;
            out_ld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            x_sel_q  <= x_sel_d;
            y_sel_q  <= y_sel_d;
            x_ld_q   <= x_ld_d;
            y_ld_q   <= y_ld_d;
            out_ld_q <= out_ld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x_sel  = x_sel_q;
    assign y_sel  = y_sel_q;
    assign x_ld   = x_ld_q;
    assign y_ld   = y_ld_q;
    assign out_ld = out_ld_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Bench for gcd_ctrl_fsm: two instances (MAX_ITER 255 and 3), each closed around a
// behavioural 8-bit datapath, checked against an arithmetic GCD-by-subtraction model.
module tb_gcd_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] x_eq_y, x_gt_y, x_zero, y_zero;
    logic [1:0] x_sel, y_sel, x_ld, y_ld, out_ld, busy, done, err;
    logic [7:0] x_in [2];
    logic [7:0] y_in [2];
    logic [7:0] xr   [2];
    logic [7:0] yr   [2];
    logic [7:0] outr [2];

    int vectors;
    int miscompares;

    gcd_ctrl_fsm u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .x_eq_y(x_eq_y[0]), .x_gt_y(x_gt_y[0]), .x_zero(x_zero[0]), .y_zero(y_zero[0]),
        .x_sel(x_sel[0]), .y_sel(y_sel[0]), .x_ld(x_ld[0]), .y_ld(y_ld[0]),
        .out_ld(out_ld[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    gcd_ctrl_fsm #(.ITER_W(8), .MAX_ITER(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .x_eq_y(x_eq_y[1]), .x_gt_y(x_gt_y[1]), .x_zero(x_zero[1]), .y_zero(y_zero[1]),
        .x_sel(x_sel[1]), .y_sel(y_sel[1]), .x_ld(x_ld[1]), .y_ld(y_ld[1]),
        .out_ld(out_ld[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath: muxes, X/Y/output registers and comparator flags.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (x_ld[i]) xr[i] <= x_sel[i] ? x_in[i] : xr[i] - yr[i];
            if (y_ld[i]) yr[i] <= y_sel[i] ? y_in[i] : yr[i] - xr[i];
            if (out_ld[i]) outr[i] <= xr[i];
        end
    end

    always_comb begin
        x_eq_y = '0;
        x_gt_y = '0;
        x_zero = '0;
        y_zero = '0;
        for (int i = 0; i < 2; i++) begin
            x_eq_y[i] = (xr[i] == yr[i]);
            x_gt_y[i] = (xr[i] > yr[i]);
            x_zero[i] = (xr[i] == 8'd0);
            y_zero[i] = (yr[i] == 8'd0);
        end
    end

    function automatic void ref_gcd(input int xa, input int ya, input int max_iter,
                                    output int n, output bit e, output int res);
        int x, y;
        x = xa;
        y = ya;
        n = 0;
        e = 1'b0;
        while (1) begin
            if (x == 0 || y == 0) begin e = 1'b1; break; end
            if (x == y) break;
            if (n == max_iter) begin e = 1'b1; break; end
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        res = x;
    endfunction

    // Runs one operation from an IDLE negedge; cycle c is sampled at the negedge inside it.
    task automatic run_op(input int inst, input int xa, input int ya, input bit hold,
                          output int done_cyc, output int done_cnt, output int sub_loads,
                          output int sel_bad, output int busy_bad, output logic [3:0] load_sig,
                          output logic err_at_done, output logic err_next,
                          output logic busy_next, output logic [7:0] res);
        bit seen;
        seen = 1'b0;
        done_cyc = -1; done_cnt = 0; sub_loads = 0; sel_bad = 0; busy_bad = 0;
        load_sig = 4'h0; err_at_done = 1'b0; err_next = 1'b0; busy_next = 1'b1; res = 8'h00;
        x_in[inst] = 8'(xa);
        y_in[inst] = 8'(ya);
        start[inst] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3 + 2 * 255 + 8; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start[inst] = 1'b0;
            if (done[inst]) done_cnt++;
            if (seen) begin
                err_next  = err[inst];
                busy_next = busy[inst];
                res       = outr[inst];
                break;
            end
            if (c == 1) load_sig = {x_sel[inst], y_sel[inst], x_ld[inst], y_ld[inst]};
            else begin
                if (x_ld[inst] || y_ld[inst]) sub_loads++;
                if ((x_ld[inst] && x_sel[inst]) || (y_ld[inst] && y_sel[inst])) sel_bad++;
            end
            if (!busy[inst]) busy_bad++;
            if (done[inst]) begin
                done_cyc    = c;
                err_at_done = err[inst];
                seen        = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({x_sel[i], y_sel[i], x_ld[i], y_ld[i], out_ld[i], busy[i], done[i], err[i]} !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs inst%0d: got %b want 00000000", i,
                         {x_sel[i], y_sel[i], x_ld[i], y_ld[i], out_ld[i], busy[i], done[i], err[i]});
            end
        end
        start = 2'b11;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_ignores_start: busy got %b want 00", busy);
        end
        start = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: busy got %b want 00", busy);
        end
    endtask

    task automatic test_directed();
        int tbl_inst [7] = '{0, 0, 0, 0, 0, 1, 0};
        int tbl_x    [7] = '{12, 9, 0, 5, 255, 255, 1};
        int tbl_y    [7] = '{8, 9, 5, 0, 1, 1, 255};
        int dc, dn, sl, sb, bb, n, r;
        logic [3:0] ls;
        logic ed, en, bn;
        logic [7:0] res;
        bit e;
        for (int k = 0; k < 7; k++) begin
            ref_gcd(tbl_x[k], tbl_y[k], (tbl_inst[k] == 0) ? 255 : 3, n, e, r);
            run_op(tbl_inst[k], tbl_x[k], tbl_y[k], 1'b0, dc, dn, sl, sb, bb, ls, ed, en, bn, res);
            vectors++;
            if (dc !== 3 + 2 * n) begin miscompares++;
                $display("[TB] FAIL dir%0d done_cycle: got %0d want %0d", k, dc, 3 + 2 * n); end
            vectors++;
            if (dn !== 1) begin miscompares++;
                $display("[TB] FAIL dir%0d done_width: got %0d want 1", k, dn); end
            vectors++;
            if (ed !== e || en !== e) begin miscompares++;
                $display("[TB] FAIL dir%0d err: got %b/%b want %b", k, ed, en, e); end
            vectors++;
            if (res !== 8'(r)) begin miscompares++;
                $display("[TB] FAIL dir%0d result: got %0d want %0d", k, res, r); end
            vectors++;
            if (sl !== n || sb !== 0 || ls !== 4'b1111) begin miscompares++;
                $display("[TB] FAIL dir%0d loads: got sub=%0d selbad=%0d load=%b want sub=%0d selbad=0 load=1111",
                         k, sl, sb, ls, n); end
            vectors++;
            if (bb !== 0 || bn !== 1'b0) begin miscompares++;
                $display("[TB] FAIL dir%0d busy: got lowcycles=%0d after=%b want 0/0", k, bb, bn); end
        end
    endtask

    task automatic test_random();
        int dc, dn, sl, sb, bb, n, r, xa, ya, inst;
        logic [3:0] ls;
        logic ed, en, bn;
        logic [7:0] res;
        bit e;
        for (int k = 0; k < 16; k++) begin
            inst = (k < 10) ? 0 : 1;
            xa = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            ya = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            ref_gcd(xa, ya, (inst == 0) ? 255 : 3, n, e, r);
            run_op(inst, xa, ya, 1'b0, dc, dn, sl, sb, bb, ls, ed, en, bn, res);
            vectors++;
            if (dc !== 3 + 2 * n || dn !== 1) begin miscompares++;
                $display("[TB] FAIL rnd inst%0d (%0d,%0d) done: got cycle=%0d count=%0d want cycle=%0d count=1",
                         inst, xa, ya, dc, dn, 3 + 2 * n); end
            vectors++;
            if (ed !== e || en !== e || res !== 8'(r)) begin miscompares++;
                $display("[TB] FAIL rnd inst%0d (%0d,%0d) result: got err=%b/%b out=%0d want err=%b out=%0d",
                         inst, xa, ya, ed, en, res, e, r); end
            vectors++;
            if (sl !== n || sb !== 0 || bb !== 0 || bn !== 1'b0) begin miscompares++;
                $display("[TB] FAIL rnd inst%0d (%0d,%0d) ctrl: got sub=%0d selbad=%0d busylow=%0d after=%b want sub=%0d",
                         inst, xa, ya, sl, sb, bb, bn, n); end
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, sl, sb, bb;
        logic [3:0] ls;
        logic ed, en, bn;
        logic [7:0] res;
        for (int k = 0; k < 3; k++) begin
            run_op(0, 6, 4, (k < 2), dc, dn, sl, sb, bb, ls, ed, en, bn, res);
            vectors++;
            if (dc !== 7 || dn !== 1) begin miscompares++;
                $display("[TB] FAIL b2b run%0d done: got cycle=%0d count=%0d want cycle=7 count=1", k, dc, dn); end
            vectors++;
            if (res !== 8'd2 || ed !== 1'b0 || bn !== 1'b0) begin miscompares++;
                $display("[TB] FAIL b2b run%0d result: got out=%0d err=%b busy_after=%b want 2/0/0", k, res, ed, bn); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        int dc, dn, sl, sb, bb;
        logic [3:0] ls;
        logic ed, en, bn;
        logic [7:0] res;
        x_in[0] = 8'd12;
        y_in[0] = 8'd8;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (busy[0] !== 1'b1) begin miscompares++;
            $display("[TB] FAIL midrun_busy: got %b want 1", busy[0]); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({x_sel[0], y_sel[0], x_ld[0], y_ld[0], out_ld[0], busy[0], done[0], err[0]} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got %b want 00000000",
                     {x_sel[0], y_sel[0], x_ld[0], y_ld[0], out_ld[0], busy[0], done[0], err[0]});
        end
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done[0] || busy[0]) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done[0] || busy[0]) saw_done = 1'b1;
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++;
            $display("[TB] FAIL abandoned_run: got done/busy activity=1 want 0"); end
        run_op(0, 12, 8, 1'b0, dc, dn, sl, sb, bb, ls, ed, en, bn, res);
        vectors++;
        if (dc !== 7 || dn !== 1 || ed !== 1'b0 || res !== 8'd4) begin miscompares++;
            $display("[TB] FAIL post_reset_run: got cycle=%0d count=%0d err=%b out=%0d want 7/1/0/4", dc, dn, ed, res); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 2'b00;
        for (int i = 0; i < 2; i++) begin
            x_in[i] = 8'd0;
            y_in[i] = 8'd0;
        end
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_ctrl_fsm.md
# gcd_ctrl_fsm

Control sequencer for the dedicated GCD microprocessor: it drives the select and load inputs of the 8-bit datapath (2:1 input muxes, X/Y registers, output register) and consumes the comparator status flags the datapath returns. It computes GCD(X, Y) by repeated subtraction, with a `start`/`done` handshake to the host. It also guards against non-terminating operands, either zero input or an iteration overrun.

## Interface
Parameters:
- `ITER_W`, 8: width of the subtraction-iteration counter.
- `MAX_ITER`, 255: maximum subtractions before the run aborts with error; must be < 2^ITER_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: host request; sampled only in IDLE.
- `x_eq_y` in 1: datapath flag, X register == Y register.
- `x_gt_y` in 1: datapath flag, X register > Y register.
- `x_zero` in 1: datapath flag, X register == 0.
- `y_zero` in 1: datapath flag, Y register == 0.
- `x_sel` out 1: X mux op; 1 = external input, 0 = subtractor result.
- `y_sel` out 1: Y mux op; 1 = external input, 0 = subtractor result.
- `x_ld` out 1: load enable for the X register.
- `y_ld` out 1: load enable for the Y register.
- `out_ld` out 1: load enable for the output register, which captures X.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: registered error flag; valid from `done`, held until the next LOAD.

## Operation
- Moore FSM with states IDLE, LOAD, CHECK, SUBX, SUBY, DONE. Outputs other than `err` are a decode of the state register.
- IDLE: all control outputs 0. If `start`=1, go to LOAD.
- LOAD: `x_sel`=`y_sel`=1 and `x_ld`=`y_ld`=1. The iteration counter clears to 0 and `err` clears. Go to CHECK.
- CHECK: no loads. Transitions are evaluated in priority order:
  1. If `x_zero` or `y_zero`, set `err` and go to DONE.
  2. Else if `x_eq_y`, go to DONE with `err`=0.
  3. Else if counter == MAX_ITER, set `err` and go to DONE.
  4. Else if `x_gt_y`, go to SUBX.
  5. Else go to SUBY.
- SUBX: `x_sel`=0 and `x_ld`=1, so X ← X−Y. Counter increments. Go to CHECK.
- SUBY: `y_sel`=0 and `y_ld`=1, so Y ← Y−X. Counter increments. Go to CHECK.
- DONE: `out_ld`=1 and `done`=1 for exactly one cycle, then IDLE.
- Unused state encodings return to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarted. `start` held high through DONE starts a new run from the following IDLE cycle.
- The counter saturates at MAX_ITER. It never wraps.
- Mux select outputs are don't-care for the datapath when the matching load is 0, but they must still be driven to the values listed above.

## Timing
- Reset (`rst_n`=0, asynchronous): state = IDLE, counter = 0, `err`=0. All outputs read 0 immediately, independent of `clk`.
- Reset mid-run: the run is abandoned with no `done` pulse. Operation resumes in IDLE on the first edge after `rst_n` rises.
- Let cycle 0 be the edge at which `start` is sampled in IDLE. Then LOAD occupies cycle 1 and the first CHECK cycle 2.
- Each subtraction costs 2 cycles (SUB + CHECK).
- `done` is asserted in cycle 3+2N, where N is the number of subtractions performed.
- Status flags must be stable during CHECK. They are combinational from the registers loaded at the preceding edge, so the datapath adds zero latency.
- `busy` rises in cycle 1 and falls after the DONE cycle.
- The minimum start-to-start interval is 4 cycles (IDLE, LOAD, CHECK, DONE).

## Test plan
- Operands (12, 8), `start` pulse at cycle 0 → loads SUBX then SUBY. `done` at cycle 7 with `err`=0; the output register captures 4; `busy` high for cycles 1–7.
- Operands (9, 9) → no subtraction; `done` at cycle 3; output = 9; `err`=0.
- Operands (0, 5) → CHECK goes directly to DONE; `done` at cycle 3 with `err`=1; no `x_ld`/`y_ld` after LOAD.
- Operands (255, 1) with MAX_ITER=255 → 254 SUBX iterations; `done` at cycle 511; output = 1; `err`=0. Same operands with MAX_ITER=3 → `done` at cycle 9 with `err`=1.
- `start` held high continuously, operands (6, 4) → back-to-back runs. Each `done` pulse is exactly one cycle, and the second LOAD begins two cycles after the first `done`.
- `rst_n` driven low mid-run at cycle 4 of (12, 8), asynchronously between edges → all outputs go to 0 immediately with no `done` pulse. After release, a fresh `start` completes normally with `err`=0.
